// File: rtl/grf_mp.sv
// Multi-port general-purpose register file with byte-enable writeback,
// optional write-to-read bypass and a per-register busy scoreboard.
module grf_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int TRACE  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rbusy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W/8-1:0]        wbe,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       alloc_en,
  input  logic [ADDR_W-1:0]          alloc_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic              commit_s;
  logic              alloc_s;
  logic [DATA_W-1:0] merged_s;

  // Commit/alloc qualification and byte merge against the current contents.
  always_comb begin
    commit_s = !reset && we && (waddr != {ADDR_W{1'b0}}) && (wbe != {NB{1'b0}});
    alloc_s  = !reset && alloc_en && (alloc_addr != {ADDR_W{1'b0}});
    merged_s = regs_r[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) begin
        merged_s[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = regs_r[waddr][8*i +: 8];
      end
    end
  end

  // Storage and scoreboard; a same-edge alloc overrides the commit's clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      busy_r <= {DEPTH{1'b0}};
    end else begin
      if (commit_s) begin
        regs_r[waddr] <= merged_s;
        busy_r[waddr] <= 1'b0;
      end
      if (alloc_s) begin
        busy_r[alloc_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;
    logic              rb_s;
    logic              hit_s;

    assign ra_s  = raddr[k*ADDR_W +: ADDR_W];
    assign hit_s = (BYPASS != 0) && commit_s && (waddr == ra_s);

    // Per-port read mux; r0 is hardwired to zero and never busy.
    always_comb begin
      if (ra_s == {ADDR_W{1'b0}}) begin
        rd_s = {DATA_W{1'b0}};
        rb_s = 1'b0;
      end else if (hit_s) begin
        rd_s = merged_s;
        if (alloc_en && (alloc_addr == ra_s)) begin
          rb_s = busy_r[ra_s];
        end else begin
          rb_s = 1'b0;
        end
      end else begin
        rd_s = regs_r[ra_s];
        rb_s = busy_r[ra_s];
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd_s;
    assign rbusy[k]                  = rb_s;
  end

  if (TRACE != 0) begin : g_trace
    // Simulation-only commit log; ignored by synthesis.
    always_ff @(posedge clk) begin
      if (commit_s) begin
        $display("@%h: $%0d <= %h", pc, waddr, merged_s);
      end
    end
  end

endmodule

// File: tb/tb_grf_mp.sv
// Scoreboard bench for grf_mp (3 read ports, bypass on): a driver pushes
// model-predicted read results, a monitor pops and compares each cycle.
module tb_grf_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h0040_0000;
  logic [14:0] raddr = 15'd0;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [3:0]  wbe = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        alloc_en = 1'b0;
  logic [4:0]  alloc_addr = 5'd0;

  always #5 clk = ~clk;

  grf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .BYPASS(1), .TRACE(1)) dut (
    .clk(clk), .reset(reset), .pc(pc), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr)
  );

  typedef struct packed {
    logic [95:0] d;
    logic [2:0]  b;
    logic [14:0] a;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [32];
  bit          busy_m [32];
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // Architectural effect of the inputs present at a rising edge.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = 32'd0;
        busy_m[i] = 1'b0;
      end
    end else begin
      if (we && waddr != 5'd0 && wbe != 4'd0) begin
        mem[waddr] = merge(mem[waddr], wdata, wbe);
        busy_m[waddr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 5'd0) busy_m[alloc_addr] = 1'b1;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    bit   c;
    c = !reset && we && waddr != 5'd0 && wbe != 4'd0;
    e.a = raddr;
    for (int k = 0; k < 3; k++) begin
      logic [4:0] a;
      a = raddr[5*k +: 5];
      if (a == 5'd0) begin
        e.d[32*k +: 32] = 32'd0;
        e.b[k] = 1'b0;
      end else if (c && waddr == a) begin
        e.d[32*k +: 32] = merge(mem[a], wdata, wbe);
        e.b[k] = (alloc_en && alloc_addr == a) ? busy_m[a] : 1'b0;
      end else begin
        e.d[32*k +: 32] = mem[a];
        e.b[k] = busy_m[a];
      end
    end
    q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [14:0] ra, input logic w,
                       input logic [4:0] wa, input logic [3:0] be, input logic [31:0] wd,
                       input logic al, input logic [4:0] aa);
    @(posedge clk);
    #1;
    model_edge();
    reset = rst; raddr = ra; we = w; waddr = wa; wbe = be; wdata = wd;
    alloc_en = al; alloc_addr = aa; pc = pc + 32'd4;
    push_expected();
  endtask

  function automatic logic [14:0] ra3(input logic [4:0] a0, input logic [4:0] a1,
                                      input logic [4:0] a2);
    return {a2, a1, a0};
  endfunction

  // Monitor: outputs are combinational and valid every cycle; check mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (rdata[32*k +: 32] !== e.d[32*k +: 32] || rbusy[k] !== e.b[k]) begin
          n_fail++;
          $display("FAIL rd%0d addr=%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   k, e.a[5*k +: 5], rdata[32*k +: 32], rbusy[k], e.d[32*k +: 32], e.b[k]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'd0;
      busy_m[i] = 1'b0;
    end
    drive(1'b1, ra3(5'd5, 5'd1, 5'd2), 1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd5, 5'd1, 5'd2), 1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd5, 5'd0, 5'd6), 1'b1, 5'd5, 4'hF, 32'h1234_5678, 1'b1, 5'd6);
    drive(1'b1, ra3(5'd5, 5'd6, 5'd6), 1'b1, 5'd6, 4'hF, 32'h5555_AAAA, 1'b1, 5'd5);
    drive(1'b0, ra3(5'd6, 5'd5, 5'd0), 1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd0, 5'd0, 5'd0), 1'b1, 5'd0, 4'hF, 32'hDEAD_BEEF, 1'b1, 5'd0);
    drive(1'b0, ra3(5'd0, 5'd0, 5'd0), 1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd3, 5'd0, 5'd3), 1'b1, 5'd3, 4'hF, 32'h1122_3344, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd3, 5'd3, 5'd0), 1'b1, 5'd3, 4'b0101, 32'hAABB_CCDD, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd3, 5'd7, 5'd0), 1'b1, 5'd7, 4'hF, 32'hCAFE_F00D, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd9, 5'd7, 5'd3), 1'b0, 5'd0, 4'h0, 32'd0, 1'b1, 5'd9);
    drive(1'b0, ra3(5'd9, 5'd9, 5'd9), 1'b1, 5'd9, 4'h0, 32'h0BAD_0BAD, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd9, 5'd9, 5'd9), 1'b1, 5'd9, 4'hF, 32'h0000_0009, 1'b1, 5'd9);
    drive(1'b0, ra3(5'd9, 5'd0, 5'd9), 1'b1, 5'd9, 4'hF, 32'h0000_0019, 1'b0, 5'd0);
    drive(1'b0, ra3(5'd9, 5'd9, 5'd9), 1'b1, 5'd9, 4'hF, 32'h0000_0029, 1'b1, 5'd9);
    drive(1'b0, ra3(5'd9, 5'd7, 5'd3), 1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0);

    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa, aa, r0, r1, r2;
      logic [3:0] be;
      wa = 5'($urandom_range(0, 7));
      aa = 5'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 7));
      be = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 49) == 0), ra3(r0, r1, r2), ($urandom_range(0, 9) < 7),
            wa, be, $urandom, ($urandom_range(0, 9) < 3), aa);
    end
    drive(1'b0, ra3(5'd1, 5'd2, 5'd3), 1'b0, 5'd0, 4'h0, 32'd0, 1'b0, 5'd0);

    repeat (2) @(posedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
